// File: rtl/regfile_write_arbiter_pkg.sv
// Shared sizing defaults and the requester-index type for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int NREQ_DEF = 3;
  localparam int AW_DEF   = 3;
  localparam int DW_DEF   = 16;

  typedef logic [1:0] req_idx_t;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic req_idx_t next_idx(input req_idx_t idx, input int n);
    return (int'(idx) == n - 1) ? req_idx_t'(0) : idx + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between the requesters (master) and the arbiter (slave).
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);

endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester at or after ptr, wrapping.
module rr_pick
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] valid_i,
  input  req_idx_t        ptr_i,
  output logic [NREQ-1:0] grant_o,
  output req_idx_t        idx_o,
  output logic            any_o
);

  int j;

  // Scan from the farthest offset back to ptr so the nearest valid requester overwrites the rest.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (valid_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = req_idx_t'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter selecting one register-file write per cycle from NREQ requesters.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  regfile_write_arbiter_if.slave        req_if,
  output logic                          reg_write,
  output logic [AW-1:0]                 write_reg,
  output logic [DW-1:0]                 write_data,
  output req_idx_t                      grant_id
);

  req_idx_t        ptr_q, ptr_d;
  req_idx_t        win_idx;
  logic [NREQ-1:0] pick_onehot;
  logic            pick_any;
  logic            xfer;

  logic            reg_write_q, reg_write_d;
  logic [AW-1:0]   write_reg_q, write_reg_d;
  logic [DW-1:0]   write_data_q, write_data_d;
  req_idx_t        grant_id_q, grant_id_d;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .valid_i (req_if.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_onehot),
    .idx_o   (win_idx),
    .any_o   (pick_any)
  );

  // A registered write already on the outputs is unaffected by stall; stall only blocks new grants.
  assign xfer             = pick_any & ~stall & ~rst;
  assign req_if.req_ready = xfer ? pick_onehot : '0;

  always_comb begin
    ptr_d        = ptr_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    grant_id_d   = grant_id_q;
    if (xfer) begin
      ptr_d        = next_idx(win_idx, NREQ);
      reg_write_d  = 1'b1;
      write_reg_d  = req_if.req_addr[int'(win_idx)*AW +: AW];
      write_data_d = req_if.req_data[int'(win_idx)*DW +: DW];
      grant_id_d   = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      grant_id_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 3;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  req_idx_t      grant_id;

  regfile_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) rif ();

  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req_if     (rif),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Requester-side view.
  bit      vld  [NREQ];
  int      addr [NREQ];
  int      data [NREQ];

  // Behavioural model of the arbiter's architectural state.
  int      m_ptr;
  bit      m_we;
  int      m_reg;
  int      m_data;
  int      m_gid;
  int      last_w;

  // Register file written by the DUT outputs.
  logic [DW-1:0] rf_shadow [8];

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      rif.req_valid[i]          = vld[i];
      rif.req_addr[i*AW +: AW]  = AW'(addr[i]);
      rif.req_data[i*DW +: DW]  = DW'(data[i]);
    end
    #1;
  endtask

  function automatic int model_pick();
    if (rst || stall) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (vld[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int w;
    r = '0;
    w = model_pick();
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    int w;
    w = model_pick();
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_ptr = 0; m_we = 0; m_reg = 0; m_data = 0; m_gid = 0;
      last_w = -1;
    end else if (w >= 0) begin
      m_we = 1; m_reg = addr[w]; m_data = data[w] & 16'hFFFF; m_gid = w;
      m_ptr = (w + 1) % NREQ;
      last_w = w;
    end else begin
      m_we = 0;
      last_w = -1;
    end
    #1;
    if (reg_write === 1'b1) begin
      rf_shadow[write_reg] = write_data;
      $display("cyc %0d write gid=%0d reg=%0d data=%h", cyc, grant_id, write_reg, write_data);
    end
  endtask

  task automatic set_all(input bit v);
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = v; addr[i] = i + 1; data[i] = 16'hA000 + i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0;
    set_all(1'b1);
    drive();
    for (int c = 0; c < 2; c++) begin
      total++;
      if (rif.req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", rif.req_ready); end
      tick();
      total++;
      if (reg_write !== 1'b0 || grant_id !== 2'd0 || write_data !== 16'h0) begin
        bad++; $display("FAIL reset_outputs got we=%b gid=%0d data=%h want we=0 gid=0 data=0", reg_write, grant_id, write_data);
      end
    end
    rst = 1'b0;
    drive();
    total++;
    if (rif.req_ready !== 3'b001) begin bad++; $display("FAIL reset_first_grant got=%b want=001", rif.req_ready); end
    set_all(1'b0);
    drive();
  endtask

  task automatic test_single();
    set_all(1'b0);
    vld[1] = 1'b1; addr[1] = 5; data[1] = 16'hBEEF;
    drive();
    total++;
    if (rif.req_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b want=010", rif.req_ready); end
    tick();
    vld[1] = 1'b0;
    drive();
    total++;
    if (reg_write !== 1'b1 || write_reg !== 3'd5 || write_data !== 16'hBEEF || grant_id !== 2'd1) begin
      bad++; $display("FAIL single_write got we=%b reg=%0d data=%h gid=%0d want 1/5/BEEF/1", reg_write, write_reg, write_data, grant_id);
    end
    tick();
    total++;
    if (reg_write !== 1'b0 || write_reg !== 3'd5 || write_data !== 16'hBEEF || grant_id !== 2'd1) begin
      bad++; $display("FAIL single_hold got we=%b reg=%0d data=%h gid=%0d want 0/5/BEEF/1", reg_write, write_reg, write_data, grant_id);
    end
  endtask

  task automatic test_back_to_back();
    int want_gid [6] = '{0, 1, 2, 0, 1, 2};
    rst = 1'b1;
    set_all(1'b0);
    drive();
    tick();
    rst = 1'b0;
    set_all(1'b1);
    drive();
    for (int c = 0; c < 6; c++) begin
      tick();
      if (last_w >= 0) data[last_w] = data[last_w] + 16'h10;
      drive();
      total++;
      if (reg_write !== 1'b1 || grant_id !== 2'(want_gid[c])) begin
        bad++; $display("FAIL b2b_order step%0d got we=%b gid=%0d want we=1 gid=%0d", c, reg_write, grant_id, want_gid[c]);
      end
    end
    set_all(1'b0);
    drive();
    tick();
  endtask

  task automatic test_stall();
    set_all(1'b0);
    vld[2] = 1'b1; addr[2] = 6; data[2] = 16'h5A5A;
    stall = 1'b1;
    drive();
    for (int c = 0; c < 3; c++) begin
      total++;
      if (rif.req_ready !== 3'b000) begin bad++; $display("FAIL stall_ready c%0d got=%b want=000", c, rif.req_ready); end
      tick();
      total++;
      if (reg_write !== 1'b0) begin bad++; $display("FAIL stall_write c%0d got=%b want=0", c, reg_write); end
    end
    stall = 1'b0;
    drive();
    total++;
    if (rif.req_ready !== 3'b100) begin bad++; $display("FAIL stall_release got=%b want=100", rif.req_ready); end
    tick();
    vld[2] = 1'b0;
    drive();
    total++;
    if (reg_write !== 1'b1 || grant_id !== 2'd2 || write_data !== 16'h5A5A) begin
      bad++; $display("FAIL stall_grant got we=%b gid=%0d data=%h want 1/2/5A5A", reg_write, grant_id, write_data);
    end
  endtask

  task automatic test_same_addr();
    set_all(1'b0);
    vld[1] = 1'b1; addr[1] = 0; data[1] = 16'h0001;
    drive();
    tick();
    vld[1] = 1'b0;
    vld[0] = 1'b1; addr[0] = 3; data[0] = 16'h1111;
    vld[2] = 1'b1; addr[2] = 3; data[2] = 16'h2222;
    drive();
    total++;
    if (rif.req_ready !== 3'b100) begin bad++; $display("FAIL same_addr_first got=%b want=100", rif.req_ready); end
    tick();
    vld[2] = 1'b0;
    drive();
    total++;
    if (rif.req_ready !== 3'b001 || write_data !== 16'h2222) begin
      bad++; $display("FAIL same_addr_second got ready=%b data=%h want 001/2222", rif.req_ready, write_data);
    end
    tick();
    vld[0] = 1'b0;
    drive();
    tick();
    total++;
    if (rf_shadow[3] !== 16'h1111) begin bad++; $display("FAIL same_addr_final got=%h want=1111", rf_shadow[3]); end
  endtask

  task automatic test_reset_mid();
    set_all(1'b0);
    vld[1] = 1'b1; addr[1] = 2; data[1] = 16'h7777;
    drive();
    tick();
    total++;
    if (m_ptr != 2) begin bad++; $display("FAIL rstmid_setup model ptr=%0d want=2", m_ptr); end
    set_all(1'b1);
    rst = 1'b1;
    drive();
    total++;
    if (reg_write !== 1'b1 || grant_id !== 2'd1 || write_data !== 16'h7777 || rif.req_ready !== 3'b000) begin
      bad++; $display("FAIL rstmid_inflight got we=%b gid=%0d data=%h ready=%b want 1/1/7777/000", reg_write, grant_id, write_data, rif.req_ready);
    end
    tick();
    total++;
    if (reg_write !== 1'b0 || rif.req_ready !== 3'b000) begin
      bad++; $display("FAIL rstmid_after got we=%b ready=%b want 0/000", reg_write, rif.req_ready);
    end
    rst = 1'b0;
    drive();
    total++;
    if (rif.req_ready !== 3'b001) begin bad++; $display("FAIL rstmid_ptr got=%b want=001", rif.req_ready); end
    set_all(1'b0);
    drive();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'($urandom_range(0, 1)); addr[i] = $urandom_range(0, 7); data[i] = $urandom_range(0, 16'hFFFF);
    end
    for (int c = 0; c < 300; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      rst   = ($urandom_range(0, 39) == 0);
      drive();
      total++;
      if (rif.req_ready !== exp_ready()) begin
        bad++; $display("FAIL rand_ready c%0d got=%b want=%b", c, rif.req_ready, exp_ready());
      end
      tick();
      total++;
      if (reg_write !== m_we || grant_id !== 2'(m_gid) || write_reg !== AW'(m_reg) || write_data !== DW'(m_data)) begin
        bad++; $display("FAIL rand_out c%0d got we=%b gid=%0d reg=%0d data=%h want %0d/%0d/%0d/%h",
                        c, reg_write, grant_id, write_reg, write_data, m_we, m_gid, m_reg, m_data);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (rst || i == last_w || !vld[i]) begin
          vld[i] = 1'($urandom_range(0, 1)); addr[i] = $urandom_range(0, 7); data[i] = $urandom_range(0, 16'hFFFF);
        end
      end
    end
    rst = 1'b0; stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    rif.req_valid = '0; rif.req_addr = '0; rif.req_data = '0;
    m_ptr = 0; m_we = 0; m_reg = 0; m_data = 0; m_gid = 0; last_w = -1;
    for (int r = 0; r < 8; r++) rf_shadow[r] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_same_addr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
